// File: rtl/modulo_time_counter.sv
// Modulo time-field counter with run carry, load, and up/down setting.
// Press-and-hold auto-repeat; BCD digits decoded from the count.
module modulo_time_counter #(
    parameter int MODULUS       = 24,
    parameter int WIDTH         = 6,
    parameter int HOLD_DELAY    = 25000000,
    parameter int REPEAT_PERIOD = 5000000,
    parameter int TIMER_WIDTH   = 25
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             setting,
    input  logic             up,
    input  logic             down,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] count,
    output logic             carry,
    output logic [3:0]       tens,
    output logic [3:0]       ones
);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} phase_t;

    localparam logic [WIDTH:0]       MOD_EXT   = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0]     MAX       = WIDTH'(MODULUS - 1);
    localparam logic [TIMER_WIDTH-1:0] HOLD_LAST = TIMER_WIDTH'(HOLD_DELAY - 1);
    localparam logic [TIMER_WIDTH-1:0] REP_LAST  = TIMER_WIDTH'(REPEAT_PERIOD - 1);

    phase_t                 phase;
    logic [TIMER_WIDTH-1:0] timer;
    logic                   up_q;
    logic                   down_q;
    logic                   dir_up;

    logic             both;
    logic             held;
    logic             up_edge;
    logic             down_edge;
    logic             in_range;
    logic             data_ok;
    logic [WIDTH-1:0] count_inc;
    logic [WIDTH-1:0] count_dec;
    logic [WIDTH-1:0] step_val;

    assign both      = up && down;
    assign held      = dir_up ? up : down;
    assign up_edge   = up && !up_q && !down;
    assign down_edge = down && !down_q && !up;
    assign in_range  = {1'b0, count} < MOD_EXT;
    assign data_ok   = {1'b0, data} < MOD_EXT;
    assign count_inc = (count == MAX) ? '0 : count + WIDTH'(1);
    assign count_dec = (count == '0) ? MAX : count - WIDTH'(1);
    assign step_val  = dir_up ? count_inc : count_dec;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count  <= '0;
            carry  <= 1'b0;
            up_q   <= 1'b0;
            down_q <= 1'b0;
            dir_up <= 1'b0;
            timer  <= '0;
            phase  <= IDLE;
        end else begin
            up_q   <= up;
            down_q <= down;
            carry  <= 1'b0;
            if (load) begin
                count <= data_ok ? data : '0;
                timer <= '0;
                phase <= IDLE;
            end else if (!in_range) begin
                count <= '0;
                timer <= '0;
                phase <= IDLE;
            end else if (setting) begin
                case (phase)
                    IDLE: begin
                        if (up_edge) begin
                            count  <= count_inc;
                            dir_up <= 1'b1;
                            timer  <= '0;
                            phase  <= HOLD;
                        end else if (down_edge) begin
                            count  <= count_dec;
                            dir_up <= 1'b0;
                            timer  <= '0;
                            phase  <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (!held || both) begin
                            timer <= '0;
                            phase <= IDLE;
                        end else if (timer == HOLD_LAST) begin
                            count <= step_val;
                            timer <= '0;
                            phase <= REPEAT;
                        end else begin
                            timer <= timer + TIMER_WIDTH'(1);
                        end
                    end
                    REPEAT: begin
                        if (!held || both) begin
                            timer <= '0;
                            phase <= IDLE;
                        end else if (timer == REP_LAST) begin
                            count <= step_val;
                            timer <= '0;
                        end else begin
                            timer <= timer + TIMER_WIDTH'(1);
                        end
                    end
                    default: begin
                        timer <= '0;
                        phase <= IDLE;
                    end
                endcase
            end else begin
                timer <= '0;
                phase <= IDLE;
                if (enable) begin
                    count <= count_inc;
                    carry <= (count == MAX);
                end
            end
        end
    end

    // Widened so an out-of-range count still decodes without truncation.
    always_comb begin
        tens = 4'(32'(count) / 10);
        ones = 4'(32'(count) % 10);
    end

endmodule
